// File: rtl/aes_pkg.sv
// Shared definitions for the AES stream front end: key-size codes,
// block size, the loader state encoding and the key-length helper.
package aes_pkg;

    localparam logic [1:0] MODE_128     = 2'b00;
    localparam logic [1:0] MODE_192     = 2'b01;
    localparam logic [1:0] MODE_256     = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    localparam int BLOCK_BYTES = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_KEY  = 2'd1,
        ST_LOAD_DATA = 2'd2,
        ST_HOLD      = 2'd3
    } loader_state_e;

    // Number of key bytes carried in a frame of the given key size.
    function automatic logic [5:0] key_bytes(input logic [1:0] mode);
        case (mode)
            MODE_192: return 6'd24;
            MODE_256: return 6'd32;
            default:  return 6'd16;
        endcase
    endfunction

endpackage

// File: rtl/aes_gap_timer.sv
// Idle-gap watchdog: counts enabled cycles since the last clear and flags
// the cycle on which the count would reach TIMEOUT_CYCLES (0 = never).
module aes_gap_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [W-1:0] SAT  = W'(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = (TIMEOUT_CYCLES > 0) ? W'(TIMEOUT_CYCLES - 1) : '0;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != SAT)
            cnt <= cnt + 1'b1;
    end

    // Fires on the edge that would take the count to TIMEOUT_CYCLES, so the
    // owner can abort on that same edge.
    assign expire = (TIMEOUT_CYCLES > 0) && en && !clr && (cnt >= LAST);

endmodule

// File: rtl/aes_stream_loader.sv
// Byte-serial loader that assembles an AES key and one 128-bit block from
// an 8-bit stream and presents them downstream with a valid/ready handshake.
module aes_stream_loader
    import aes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic         load_key,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    output logic         byte_ready,
    output logic [255:0] key_out,
    output logic [1:0]   key_len,
    output logic [127:0] block_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         err
);

    loader_state_e state, state_nxt;
    logic          err_nxt;

    logic [5:0]    cnt;
    logic [255:0]  key_sh;
    logic [127:0]  blk_sh;
    logic [1:0]    mode_r;
    logic          load_key_r;
    logic          key_loaded;

    logic          in_load;
    logic          accept;
    logic          last_key;
    logic          last_blk;
    logic          start_ok;
    logic          gap_expire;

    assign in_load  = (state == ST_LOAD_KEY) || (state == ST_LOAD_DATA);
    assign accept   = in_load && byte_valid;
    assign last_key = (cnt == key_bytes(mode_r) - 6'd1);
    assign last_blk = (cnt == 6'(BLOCK_BYTES - 1));
    assign start_ok = (mode != MODE_ILLEGAL) && (load_key || key_loaded);

    aes_gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (accept || !in_load),
        .en     (in_load),
        .expire (gap_expire)
    );

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (!start_ok)
                        err_nxt = 1'b1;
                    else if (load_key)
                        state_nxt = ST_LOAD_KEY;
                    else
                        state_nxt = ST_LOAD_DATA;
                end
            end
            ST_LOAD_KEY: begin
                if (gap_expire) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (accept && last_key) begin
                    state_nxt = ST_LOAD_DATA;
                end
            end
            ST_LOAD_DATA: begin
                if (gap_expire) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (accept && last_blk) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            err        <= 1'b0;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            state      <= state_nxt;
            err        <= err_nxt;
            byte_ready <= (state_nxt == ST_LOAD_KEY) || (state_nxt == ST_LOAD_DATA);
            busy       <= (state_nxt != ST_IDLE);
            out_valid  <= (state_nxt == ST_HOLD);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            key_sh     <= '0;
            blk_sh     <= '0;
            mode_r     <= MODE_128;
            load_key_r <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (start && start_ok) begin
                cnt        <= '0;
                mode_r     <= mode;
                load_key_r <= load_key;
                if (load_key)
                    key_sh <= '0;
            end
        end else if (accept && state == ST_LOAD_KEY) begin
            // Key shadow starts cleared, so shifting MSB-first leaves the key
            // right-justified with zero padding above it.
            key_sh <= {key_sh[247:0], byte_in};
            cnt    <= last_key ? 6'd0 : cnt + 6'd1;
        end else if (accept && state == ST_LOAD_DATA) begin
            blk_sh <= {blk_sh[119:0], byte_in};
            cnt    <= cnt + 6'd1;
        end
    end

    // Presented outputs move only at commit; aborts and reuse frames leave
    // the previous key in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_out    <= '0;
            key_len    <= MODE_128;
            block_out  <= '0;
            key_loaded <= 1'b0;
        end else if (state == ST_LOAD_DATA && accept && last_blk && !gap_expire) begin
            block_out <= {blk_sh[119:0], byte_in};
            if (load_key_r) begin
                key_out    <= key_sh;
                key_len    <= mode_r;
                key_loaded <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_stream_loader.sv
// Directed and randomized bench for aes_stream_loader, checked against a
// byte-queue reference model of the assembled key and block.
module tb_aes_stream_loader;

    localparam int TO = 40;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   mode;
    logic         load_key;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic [255:0] key_out;
    logic [1:0]   key_len;
    logic [127:0] block_out;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         err;

    int checks = 0;
    int errors = 0;

    logic [255:0] m_key;
    logic [1:0]   m_len;
    logic [127:0] m_blk;
    logic [7:0]   kq[$];
    logic [7:0]   dq[$];

    aes_stream_loader #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .load_key   (load_key),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .key_out    (key_out),
        .key_len    (key_len),
        .block_out  (block_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gapmax, input string tag);
        int g;
        g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
        byte_valid = 1'b0;
        repeat (g) tick();
        byte_valid = 1'b1;
        byte_in    = b;
        for (int w = 0; w < 20 && !byte_ready; w++) tick();
        check({tag, ".byte_ready"}, byte_ready, 1);
        tick();
    endtask

    task automatic fill_q(input logic [127:0] v);
        dq.delete();
        for (int i = 0; i < 16; i++) dq.push_back(v[127 - 8*i -: 8]);
    endtask

    task automatic rand_q(input int nkey);
        kq.delete();
        dq.delete();
        for (int i = 0; i < nkey; i++) kq.push_back(8'($urandom));
        for (int i = 0; i < 16; i++) dq.push_back(8'($urandom));
    endtask

    // One complete frame: start, key bytes (if any), 16 block bytes, then
    // compare against the model once out_valid rises.
    task automatic run_frame(input logic [1:0] md, input logic lk, input int gapmax, input string tag);
        start = 1'b1; mode = md; load_key = lk;
        tick();
        start = 1'b0;
        check({tag, ".busy"}, busy, 1);
        if (lk) foreach (kq[i]) send_byte(kq[i], gapmax, tag);
        for (int i = 0; i < 15; i++) send_byte(dq[i], gapmax, tag);
        check({tag, ".no_early_valid"}, out_valid, 0);
        send_byte(dq[15], gapmax, tag);
        byte_valid = 1'b0;
        check({tag, ".out_valid"}, out_valid, 1);
        if (lk) begin
            m_key = '0;
            foreach (kq[i]) m_key = m_key * 256 + kq[i];
            m_len = md;
        end
        m_blk = '0;
        foreach (dq[i]) m_blk = m_blk * 256 + dq[i];
        check({tag, ".key_out"}, key_out, m_key);
        check({tag, ".key_len"}, key_len, m_len);
        check({tag, ".block_out"}, block_out, m_blk);
        check({tag, ".byte_ready_hold"}, byte_ready, 0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".hs_valid"}, out_valid, 0);
        check({tag, ".hs_busy"}, busy, 0);
    endtask

    initial begin
        logic [127:0] v;
        logic [255:0] k256;
        int hit;
        reset = 1'b1; start = 1'b0; mode = 2'b00; load_key = 1'b0;
        byte_in = 8'h00; byte_valid = 1'b0; out_ready = 1'b0;
        m_key = '0; m_len = 2'b00; m_blk = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst.key_out", key_out, 0);
        check("rst.block_out", block_out, 0);
        check("rst.key_len", key_len, 0);
        check("rst.byte_ready", byte_ready, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.busy", busy, 0);
        check("rst.err", err, 0);

        // reuse without a stored key
        start = 1'b1; mode = 2'b00; load_key = 1'b0;
        tick();
        start = 1'b0;
        check("nokey.err", err, 1);
        check("nokey.busy", busy, 0);
        tick();
        check("nokey.err_pulse", err, 0);

        // illegal key size
        start = 1'b1; mode = 2'b11; load_key = 1'b1;
        tick();
        start = 1'b0;
        check("mode11.err", err, 1);
        check("mode11.busy", busy, 0);
        tick();
        check("mode11.err_pulse", err, 0);

        // 128-bit key, back-to-back bytes
        kq.delete();
        for (int i = 0; i < 16; i++) kq.push_back(8'(i));
        dq.delete();
        for (int i = 0; i < 16; i++) dq.push_back(8'(i * 17));
        run_frame(2'b00, 1'b1, 0, "k128");
        check("k128.key_lit", key_out, 256'h000102030405060708090a0b0c0d0e0f);
        check("k128.blk_lit", block_out, 128'h00112233445566778899aabbccddeeff);

        // backpressure in HOLD with stream still offering bytes
        byte_valid = 1'b1; byte_in = 8'hA5;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("bp.byte_ready", byte_ready, 0);
            check("bp.out_valid", out_valid, 1);
            check("bp.block_out", block_out, m_blk);
            check("bp.err", err, 0);
        end
        // start coinciding with the handshake must be ignored
        out_ready = 1'b1; start = 1'b1; mode = 2'b00; load_key = 1'b1;
        tick();
        out_ready = 1'b0; start = 1'b0; byte_valid = 1'b0;
        check("bp.hs_valid", out_valid, 0);
        check("bp.hs_busy", busy, 0);
        tick();
        check("bp.start_ignored", busy, 0);
        check("bp.key_kept", key_out, m_key);

        // 256-bit key with random gaps
        kq.delete();
        for (int i = 0; i < 32; i++) kq.push_back(8'(i));
        fill_q(128'h00112233445566778899aabbccddeeff);
        run_frame(2'b10, 1'b1, 10, "k256");
        k256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        check("k256.key_lit", key_out, k256);
        check("k256.len_lit", key_len, 2'b10);
        handshake("k256");

        // 192-bit key, then reuse with a new block
        kq.delete();
        for (int i = 0; i < 24; i++) kq.push_back(8'(i));
        fill_q(128'h00112233445566778899aabbccddeeff);
        run_frame(2'b01, 1'b1, 3, "k192");
        handshake("k192");
        fill_q(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        run_frame(2'b01, 1'b0, 2, "reuse");
        check("reuse.key_lit", key_out, 256'h000102030405060708090a0b0c0d0e0f1011121314151617);
        check("reuse.len_lit", key_len, 2'b01);
        check("reuse.blk_lit", block_out, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        handshake("reuse");

        // randomized frames
        for (int t = 0; t < 5; t++) begin
            logic [1:0] md;
            logic lk;
            md = 2'($urandom_range(2, 0));
            lk = 1'($urandom_range(1, 0));
            rand_q(16 + 8 * md);
            run_frame(md, lk, 6, "rand");
            handshake("rand");
        end

        // timeout after 10 data bytes
        rand_q(0);
        start = 1'b1; mode = 2'b00; load_key = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) send_byte(dq[i], 2, "tmo");
        byte_valid = 1'b0;
        hit = -1;
        for (int k = 1; k <= TO + 5; k++) begin
            tick();
            if (err && hit < 0) hit = k;
        end
        check("tmo.latency", hit, TO);
        check("tmo.busy", busy, 0);
        check("tmo.out_valid", out_valid, 0);
        check("tmo.key_kept", key_out, m_key);
        check("tmo.len_kept", key_len, m_len);
        check("tmo.blk_kept", block_out, m_blk);
        rand_q(0);
        run_frame(2'b00, 1'b0, 1, "post_tmo");
        handshake("post_tmo");

        // asynchronous reset in the middle of a key load
        rand_q(24);
        start = 1'b1; mode = 2'b01; load_key = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(kq[i], 0, "arst");
        reset = 1'b1;
        #1;
        check("arst.key_out", key_out, 0);
        check("arst.block_out", block_out, 0);
        check("arst.key_len", key_len, 0);
        check("arst.byte_ready", byte_ready, 0);
        check("arst.busy", busy, 0);
        check("arst.out_valid", out_valid, 0);
        check("arst.err", err, 0);
        tick();
        reset = 1'b0; byte_valid = 1'b0;
        tick();
        check("arst.no_err", err, 0);
        start = 1'b1; mode = 2'b00; load_key = 1'b0;
        tick();
        start = 1'b0;
        check("arst.key_cleared_err", err, 1);
        check("arst.key_cleared_busy", busy, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_stream_loader.md
Name: aes_stream_loader

Overview:
Byte-serial front end that assembles an AES key (128/192/256-bit) and one 128-bit plaintext or ciphertext block from an 8-bit stream. It is the producer side of the AES datapath: it feeds KeyExpansion and AES_Cipher/AES_DeCipher, which today are fed by hard-wired literals. It presents the assembled key and block with a valid/ready handshake and holds them stable until they are consumed. A key may be loaded once and reused for later blocks.

Parameters:
TIMEOUT_CYCLES, 1024, maximum number of idle cycles allowed mid-frame with no byte accepted before the frame is aborted; 0 disables the timeout.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle frame start; sampled only in IDLE
mode  in  2  key size for the frame: 00 = 128, 01 = 192, 10 = 256, 11 = illegal; sampled with start
load_key  in  1  1 = frame carries key bytes then block bytes; 0 = block bytes only, reuse the stored key; sampled with start
byte_in  in  8  stream byte
byte_valid  in  1  byte_in is valid
byte_ready  out  1  loader can accept a byte
key_out  out  256  assembled key, right-justified, upper unused bits zero
key_len  out  2  mode code of key_out
block_out  out  128  assembled block
out_valid  out  1  key_out, key_len and block_out are valid
out_ready  in  1  downstream consumes the outputs
busy  out  1  state is not IDLE
err  out  1  one-cycle pulse on an abort or rejected start

Behaviour:
- Reset (async assert, clocked release): state IDLE; all outputs 0, including key_out, block_out, key_len, byte_ready, out_valid, busy and err. The key_loaded flag is cleared. A reset during any state aborts the frame silently, with no err pulse.
- States: IDLE, LOAD_KEY, LOAD_DATA, HOLD. All outputs are registered.
- IDLE:
  - start with mode = 11 → err pulse, stay in IDLE.
  - start with load_key = 0 and key_loaded = 0 → err pulse, stay in IDLE.
  - Other start with load_key = 1 → LOAD_KEY; the key shadow register is cleared and the counter set to 0.
  - Other start with load_key = 0 → LOAD_DATA.
- Byte transfer: a byte is accepted on any edge where byte_valid && byte_ready. byte_ready = 1 exactly in LOAD_KEY and LOAD_DATA.
- Byte order is MSB first: shadow <= {shadow, byte_in}. The first byte therefore ends up in the most significant byte, matching the hex-literal order used in FIPS-197.
- LOAD_KEY:
  - Accepts KEY_BYTES(mode) bytes: 16, 24 or 32.
  - The last key byte is accepted on cycle N; LOAD_DATA is entered at N+1 with the counter reset to 0.
- LOAD_DATA:
  - Accepts 16 bytes.
  - On the edge that accepts the 16th byte, the state moves to HOLD and the commit happens: block_out <= shadow, and, if the frame was load_key, key_out/key_len <= key shadow/mode and key_loaded <= 1.
  - out_valid = 1 from the next cycle. Latency from the last accepted byte to out_valid is 1 cycle.
- Output stability: key_out, key_len and block_out change only at commit. They remain unchanged across reuse frames and aborts.
- HOLD:
  - out_valid = 1 and byte_ready = 0.
  - out_valid && out_ready → IDLE, out_valid = 0 next cycle. Outputs keep their values after the handshake.
  - out_ready asserted outside HOLD is ignored.
- start is ignored in all states other than IDLE, including when it coincides with the final handshake.
- Timeout (TIMEOUT_CYCLES > 0):
  - A gap counter runs in LOAD_KEY/LOAD_DATA and clears on every accepted byte and on entry to these states.
  - When it reaches TIMEOUT_CYCLES: err pulse, go to IDLE, nothing is committed, and key_loaded is unchanged.
  - HOLD has no timeout.
- Counter widths: byte counter 6 bits. Gap counter $clog2(TIMEOUT_CYCLES+1) bits, saturating.

Decomposition:
- Shared package aes_pkg holds:
  - mode encodings MODE_128 / MODE_192 / MODE_256;
  - BLOCK_BYTES = 16;
  - function key_bytes(mode) returning 16/24/32;
  - the loader state enum.
- One natural sub-module: aes_gap_timer, the parameterised idle-gap counter with clear and enable inputs and an expire output.

Test Plan:
- 128-bit load: start mode = 00 load_key = 1; stream bytes 00..0f then 00 11 22 … ff with byte_valid held at 1 → out_valid exactly 1 cycle after the 32nd byte. Required values: key_out = 256'h0…000102030405060708090a0b0c0d0e0f, key_len = 00, block_out = 128'h00112233445566778899aabbccddeeff.
- 256-bit load with random byte_valid gaps shorter than TIMEOUT_CYCLES → key_out = 256'h000102…1e1f, key_len = 10, 48 bytes accepted. Feeding the outputs to the AES_Cipher NR = 14 instance gives 8ea2b7ca516745bfeafc49904b496089.
- Key reuse: after the 192-bit vector load, start load_key = 0 with block 69c4e0d86a7b0430d8cdb78070b4c55a → key_out and key_len unchanged (the 192-bit key, key_len = 01), block_out updated after 16 bytes.
- Errors:
  - start mode = 11 → err pulse for 1 cycle, busy = 0.
  - start load_key = 0 directly after reset → err pulse for 1 cycle, busy = 0.
- Backpressure: hold out_ready = 0 for 50 cycles in HOLD while byte_valid = 1 → byte_ready = 0, outputs stable, no byte consumed, no timeout. Then out_ready = 1 → IDLE next cycle.
- Abort paths:
  - Stop the stream after 10 data bytes → err pulse exactly TIMEOUT_CYCLES cycles after the last accepted byte; outputs keep their prior values.
  - Assert reset mid-LOAD_KEY → all outputs 0 immediately (asynchronously), no err pulse.
